// File: rtl/store_narrow.sv
// store_narrow: store-path narrowing into word-aligned beats with byte enables; STORE_SPLIT_EN builds two-beat boundary-crossing stores
module store_narrow (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   input  logic [1:0]  in_size,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_addr,
   output logic [31:0] out_wdata,
   output logic [3:0]  out_be,
   output logic        err
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LAST = 2'd1;
`ifdef STORE_SPLIT_EN
   localparam logic [1:0] FIRST = 2'd2;
`endif
   logic [1:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        err_q, err_d;
   logic [3:0]  m;
   logic [7:0]  mask8;
   logic [31:0] dmask;
   logic [63:0] data64;
   logic [31:0] addr0;
   logic        split, illegal, accept;
`ifdef STORE_SPLIT_EN
   logic [31:0] b1_addr_q, b1_addr_d;
   logic [31:0] b1_wdata_q, b1_wdata_d;
   logic [3:0]  b1_be_q, b1_be_d;
`else
   logic        unused_hi;
   assign unused_hi = ^data64[63:32];
`endif

   assign m      = in_size == 2'b00 ? 4'b0001 : in_size == 2'b01 ? 4'b0011 : 4'b1111;
   assign dmask  = in_size == 2'b00 ? 32'h0000_00FF : in_size == 2'b01 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   assign mask8  = {4'b0000, m} << in_addr[1:0];
   assign data64 = {32'b0, in_data & dmask} << {in_addr[1:0], 3'b000};
   assign addr0  = {in_addr[31:2], 2'b00};
   assign split  = |mask8[7:4];
`ifdef STORE_SPLIT_EN
   assign illegal = in_size == 2'b11;
`else
   assign illegal = in_size == 2'b11 || split;
`endif
   assign in_ready  = rst_n && (state_q == IDLE || (state_q == LAST && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = state_q != IDLE;
   assign out_addr  = addr_q;
   assign out_wdata = wdata_q;
   assign out_be    = be_q;
   assign err       = err_q;

   // next beat selection: accept a new store, advance a split store, or retire to idle
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      err_d   = accept && illegal;
`ifdef STORE_SPLIT_EN
      b1_addr_d  = b1_addr_q;
      b1_wdata_d = b1_wdata_q;
      b1_be_d    = b1_be_q;
`endif
      if (accept && !illegal) begin
         addr_d  = addr0;
         wdata_d = data64[31:0];
         be_d    = mask8[3:0];
`ifdef STORE_SPLIT_EN
         state_d    = split ? FIRST : LAST;
         b1_addr_d  = addr0 + 32'd4;
         b1_wdata_d = data64[63:32];
         b1_be_d    = mask8[7:4];
`else
         state_d = LAST;
`endif
      end else if (accept || (state_q == LAST && out_ready)) begin
         state_d = IDLE;
      end
`ifdef STORE_SPLIT_EN
      if (state_q == FIRST && out_ready) begin
         state_d = LAST;
         addr_d  = b1_addr_q;
         wdata_d = b1_wdata_q;
         be_d    = b1_be_q;
      end
`endif
   end

   // state and beat registers; reset discards any held or latched beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         err_q      <= 1'b0;
`ifdef STORE_SPLIT_EN
         b1_addr_q  <= '0;
         b1_wdata_q <= '0;
         b1_be_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         err_q      <= err_d;
`ifdef STORE_SPLIT_EN
         b1_addr_q  <= b1_addr_d;
         b1_wdata_q <= b1_wdata_d;
         b1_be_q    <= b1_be_d;
`endif
      end
   end
endmodule
